// File: rtl/spi_wr_bridge.sv
// rtl/spi_wr_bridge.sv - SPI receiver write request to register bus bridge
// Synchronises the SPI write strobe, queues requests in a FIFO, issues them as valid/ready bus writes.
module spi_wr_bridge #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_in,
  input  logic [ADDR_W-1:0]          wr_address_in,
  input  logic [DATA_W-1:0]          wr_data_in,
  output logic                       bus_valid,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [DATA_W-1:0]          bus_data,
  input  logic                       bus_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_overflow;
  logic [ADDR_W-1:0]      r_addr_mem [DEPTH];
  logic [DATA_W-1:0]      r_data_mem [DEPTH];

  logic w_push_req;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Chain and prev reset high: a strobe already high at reset release is not a new request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], wr_en_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_push_req = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = bus_valid & bus_ready;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= wr_address_in;
      r_data_mem[r_wptr] <= wr_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A drop at the same edge as a clear keeps the flag set.
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  assign bus_valid  = (r_count != '0);
  assign bus_addr   = bus_valid ? r_addr_mem[r_rptr] : '0;
  assign bus_data   = bus_valid ? r_data_mem[r_rptr] : '0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_spi_wr_bridge.sv
// tb/tb_spi_wr_bridge.sv - scoreboard bench for spi_wr_bridge
// Stimulus queues expected bus writes; a negedge monitor compares every accepted bus beat.
module tb_spi_wr_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en_in;
  logic [23:0] wr_address_in;
  logic [31:0] wr_data_in;
  logic        bus_valid;
  logic [23:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        overflow_clr;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int max_count = 0;
  logic [55:0] exp_q[$];

  spi_wr_bridge #(.ADDR_W(24), .DATA_W(32), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .wr_en_in(wr_en_in), .wr_address_in(wr_address_in), .wr_data_in(wr_data_in),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_data(bus_data), .bus_ready(bus_ready),
    .fifo_count(fifo_count), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus_valid && bus_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got addr 0x%0h with empty scoreboard", bus_addr);
      end else begin
        logic [55:0] e;
        e = exp_q.pop_front();
        chk("pop_addr", 64'(bus_addr), 64'(e[55:32]));
        chk("pop_data", 64'(bus_data), 64'(e[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (bus_valid) valid_cycles++;
    if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request; clr/rdy are pulsed so they are high exactly at the push edge k+2.
  task automatic send(input logic [23:0] a, input logic [31:0] d, input bit accept,
                      input bit clr, input bit rdy, input bit lat);
    if (accept) exp_q.push_back({a, d});
    wr_address_in = a;
    wr_data_in    = d;
    wr_en_in      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    if (clr) overflow_clr = 1'b1;
    if (rdy) bus_ready = 1'b1;
    if (lat) begin
      @(negedge clk);
      chk("latency_k1_valid", 64'(bus_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    if (clr) overflow_clr = 1'b0;
    if (rdy) bus_ready = 1'b0;
    if (lat) begin
      @(negedge clk);
      chk("latency_k2_valid", 64'(bus_valid), 64'd1);
    end
    cyc(2);
    wr_en_in = 1'b0;
    cyc(4);
  endtask

  task automatic drain();
    bus_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (fifo_count == 3'd0) break;
    end
    bus_ready = 1'b0;
    chk("drain_count", 64'(fifo_count), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en_in = 1'b0; wr_address_in = '0; wr_data_in = '0;
    bus_ready = 1'b0; overflow_clr = 1'b0;
    cyc(3);
    chk("rst_valid", 64'(bus_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_addr", 64'(bus_addr), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    cyc(3);

    // Single write with ready high
    bus_ready = 1'b1;
    valid_cycles = 0; max_count = 0;
    send(24'h123456, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t1_valid_cycles", 64'(valid_cycles), 64'd1);
    chk("t1_max_count", 64'(max_count), 64'd1);
    chk("t1_count", 64'(fifo_count), 64'd0);
    chk("t1_overflow", 64'(overflow), 64'd0);
    bus_ready = 1'b0;

    // Backpressure and ordering
    send(24'h000001, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b0);
    send(24'h000002, 32'h22222222, 1'b1, 1'b0, 1'b0, 1'b0);
    send(24'h000003, 32'h33333333, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_count", 64'(fifo_count), 64'd3);
    chk("t2_head_addr", 64'(bus_addr), 64'h000001);
    bus_ready = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      chk("t2_drain_count", 64'(fifo_count), 64'(i));
    end
    cyc(1);
    bus_ready = 1'b0;
    chk("t2_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Overflow and pointer wrap
    for (int i = 0; i < 5; i++)
      send(24'h000100 + 24'(i), 32'hA0000000 + 32'(i), (i < 4), 1'b0, 1'b0, 1'b0);
    chk("t3_count_full", 64'(fifo_count), 64'd4);
    chk("t3_overflow_set", 64'(overflow), 64'd1);
    chk("t3_head_addr", 64'(bus_addr), 64'h000100);
    drain();
    for (int i = 0; i < 4; i++)
      send(24'h000200 + 24'(i), 32'hB0000000 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_wrap_count", 64'(fifo_count), 64'd4);
    drain();
    overflow_clr = 1'b1; cyc(1); overflow_clr = 1'b0;
    chk("t3_overflow_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++)
      send(24'h000300 + 24'(i), 32'hC0000000 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    send(24'h0003FF, 32'hCFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_set_beats_clr", 64'(overflow), 64'd1);
    chk("t3_count_after_drop", 64'(fifo_count), 64'd4);
    overflow_clr = 1'b1; cyc(1); overflow_clr = 1'b0;
    chk("t4_overflow_pre", 64'(overflow), 64'd0);

    // Full plus simultaneous pop
    send(24'h000400, 32'hD0000000, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_count", 64'(fifo_count), 64'd4);
    chk("t4_overflow", 64'(overflow), 64'd0);
    chk("t4_head_addr", 64'(bus_addr), 64'h000301);
    drain();

    // Async reset mid-drain, strobe held across release
    for (int i = 0; i < 3; i++)
      send(24'h000500 + 24'(i), 32'hE0000000 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    bus_ready = 1'b1;
    cyc(1);
    bus_ready = 1'b0;
    chk("t5_count_pre", 64'(fifo_count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(bus_valid), 64'd0);
    chk("t5_rst_count", 64'(fifo_count), 64'd0);
    chk("t5_rst_addr", 64'(bus_addr), 64'd0);
    chk("t5_rst_data", 64'(bus_data), 64'd0);
    exp_q.delete();
    wr_en_in = 1'b1; wr_address_in = 24'h0005AA; wr_data_in = 32'h55555555;
    cyc(3);
    rst = 1'b0;
    cyc(6);
    chk("t5_no_push_count", 64'(fifo_count), 64'd0);
    wr_en_in = 1'b0;
    cyc(4);
    send(24'h000600, 32'hF0000000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_push_count", 64'(fifo_count), 64'd1);
    drain();

    // Held strobe produces one push
    max_count = 0;
    exp_q.push_back({24'h000700, 32'h77777777});
    wr_address_in = 24'h000700; wr_data_in = 32'h77777777; wr_en_in = 1'b1;
    cyc(40);
    wr_en_in = 1'b0;
    cyc(4);
    chk("t6_count", 64'(fifo_count), 64'd1);
    chk("t6_max_count", 64'(max_count), 64'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
